// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// FSM encodings and index-width helper used by the top and the picker.
package rr_grant_arbiter_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Width of an index over n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational round-robin picker.
// First eligible bit searching ptr, ptr+1, ... wrapping at N.
module rr_pick
  import rr_grant_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] pick,
  output logic          any
);

  int idx;

  // Walk offsets high to low so the nearest hit lands last.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (eligible[idx]) begin
        pick = idx[IW-1:0];
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Clocked round-robin arbiter with max-hold timeout and
// a one-cycle turnaround between owners.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int N        = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        gnt,
  output logic                gnt_valid,
  output logic [idx_w(N)-1:0] gnt_id,
  output logic                timeout
);

  localparam int IW = idx_w(N);
  localparam int HW =
    (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_ID = IW'(N - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] id_q, id_d;
  logic          vld_q, vld_d;
  logic          to_q, to_d;

  logic [N-1:0]  eligible;
  logic [IW-1:0] pick;
  logic          any;
  logic [IW-1:0] owner_nxt;

  assign eligible = req & ~mask_q;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .pick     (pick),
    .any      (any)
  );

  assign owner_nxt =
    (id_q == LAST_ID) ? '0 : id_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    mask_d  = mask_q & req;
    gnt_d   = gnt_q;
    id_d    = id_q;
    vld_d   = vld_q;
    to_d    = 1'b0;

    case (state_q)
      IDLE, RELEASE: begin
        if (any) begin
          state_d     = GRANT;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          id_d        = pick;
          vld_d       = 1'b1;
          hold_d      = HW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
          vld_d   = 1'b0;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[id_q]) begin
          state_d = RELEASE;
          gnt_d   = '0;
          id_d    = '0;
          vld_d   = 1'b0;
          hold_d  = '0;
          ptr_d   = owner_nxt;
        end else if (MAX_HOLD != 0 &&
                     hold_q == HOLD_MAX) begin
          // Owner still requesting, so this bit
          // cannot be cleared in the same cycle.
          state_d      = RELEASE;
          gnt_d        = '0;
          id_d         = '0;
          vld_d        = 1'b0;
          hold_d       = '0;
          ptr_d        = owner_nxt;
          to_d         = 1'b1;
          mask_d[id_q] = 1'b1;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
        vld_d   = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      mask_q  <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = vld_q;
  assign gnt_id    = id_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: vector table on a
// MAX_HOLD=4 instance plus a long hold on a MAX_HOLD=0 one.
module tb_rr_grant_arbiter;

  typedef struct packed {
    logic       rst;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] id;
    logic       to;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [2:0] req, req2;
  logic [2:0] gnt, gnt2;
  logic       vld, vld2;
  logic [1:0] id, id2;
  logic       to, to2;

  int applied = 0;
  int errs    = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  rr_grant_arbiter #(.N(3), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (vld),
    .gnt_id    (id),
    .timeout   (to)
  );

  rr_grant_arbiter #(.N(3), .MAX_HOLD(0)) dut0 (
    .clk       (clk),
    .rst       (rst2),
    .req       (req2),
    .gnt       (gnt2),
    .gnt_valid (vld2),
    .gnt_id    (id2),
    .timeout   (to2)
  );

  task automatic add(input logic r, input logic [2:0] q,
                     input logic [2:0] g, input logic [1:0] i,
                     input logic t);
    vec_t v;
    v = '{r, q, g, i, t};
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input int n,
                       input logic [2:0] g, input logic [1:0] i,
                       input logic v, input logic t,
                       input logic [2:0] eg, input logic [1:0] ei,
                       input logic et);
    logic ev;
    ev = |eg;
    applied++;
    if (g !== eg || i !== ei || v !== ev || t !== et ||
        $countones(g) > 1) begin
      errs++;
      $display("FAIL %s #%0d: gnt=%b id=%0d valid=%b to=%b, want gnt=%b id=%0d valid=%b to=%b",
               nm, n, g, i, v, t, eg, ei, ev, et);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 3'b000;
    rst2 = 1'b1;
    req2 = 3'b000;

    // reset held with all requests, then 3-way rotation with timeouts
    add(1, 3'b111, 3'b000, 0, 0);
    add(1, 3'b111, 3'b000, 0, 0);
    add(0, 3'b111, 3'b001, 0, 0);
    add(0, 3'b111, 3'b001, 0, 0);
    add(0, 3'b111, 3'b001, 0, 0);
    add(0, 3'b111, 3'b001, 0, 0);
    add(0, 3'b111, 3'b000, 0, 1);
    add(0, 3'b111, 3'b010, 1, 0);
    add(0, 3'b111, 3'b010, 1, 0);
    add(0, 3'b111, 3'b010, 1, 0);
    add(0, 3'b111, 3'b010, 1, 0);
    add(0, 3'b111, 3'b000, 0, 1);
    add(0, 3'b111, 3'b100, 2, 0);
    add(0, 3'b111, 3'b100, 2, 0);
    add(0, 3'b111, 3'b100, 2, 0);
    add(0, 3'b111, 3'b100, 2, 0);
    add(0, 3'b111, 3'b000, 0, 1);
    add(0, 3'b111, 3'b000, 0, 0);
    add(0, 3'b111, 3'b000, 0, 0);
    // req[0] drops and returns: only it is unmasked
    add(0, 3'b110, 3'b000, 0, 0);
    add(0, 3'b111, 3'b001, 0, 0);
    // req=011, owner 0 drops, handoff to 1 after gap
    add(1, 3'b000, 3'b000, 0, 0);
    add(0, 3'b011, 3'b001, 0, 0);
    add(0, 3'b011, 3'b001, 0, 0);
    add(0, 3'b010, 3'b000, 0, 0);
    add(0, 3'b010, 3'b010, 1, 0);
    // req[1] stuck high: timeout, then locked out
    add(0, 3'b010, 3'b010, 1, 0);
    add(0, 3'b010, 3'b010, 1, 0);
    add(0, 3'b010, 3'b010, 1, 0);
    add(0, 3'b010, 3'b000, 0, 1);
    add(0, 3'b010, 3'b000, 0, 0);
    add(0, 3'b010, 3'b000, 0, 0);
    add(0, 3'b000, 3'b000, 0, 0);
    add(0, 3'b010, 3'b010, 1, 0);
    // no preemption, then ptr=2 picks requester 2
    add(0, 3'b111, 3'b010, 1, 0);
    add(0, 3'b101, 3'b000, 0, 0);
    add(0, 3'b101, 3'b100, 2, 0);
    add(0, 3'b101, 3'b100, 2, 0);
    // reset mid-grant, then fresh full-length grant
    add(1, 3'b101, 3'b000, 0, 0);
    add(0, 3'b101, 3'b001, 0, 0);
    add(0, 3'b101, 3'b001, 0, 0);
    add(0, 3'b101, 3'b001, 0, 0);
    add(0, 3'b101, 3'b001, 0, 0);
    add(0, 3'b101, 3'b000, 0, 1);
    add(0, 3'b101, 3'b100, 2, 0);

    for (int k = 0; k < vq.size(); k++) begin
      rst = vq[k].rst;
      req = vq[k].req;
      @(posedge clk);
      #1;
      check("vec", k, gnt, id, vld, to,
            vq[k].gnt, vq[k].id, vq[k].to);
    end

    // MAX_HOLD=0: ownership never times out
    rst = 1'b1;
    req = 3'b000;
    rst2 = 1'b1;
    req2 = 3'b001;
    @(posedge clk);
    #1;
    check("hold0_rst", 0, gnt2, id2, vld2, to2, 3'b000, 0, 0);
    rst2 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      check("hold0", k, gnt2, id2, vld2, to2, 3'b001, 0, 0);
    end
    req2 = 3'b000;
    @(posedge clk);
    #1;
    check("hold0_drop", 0, gnt2, id2, vld2, to2, 3'b000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, errs);
    $finish;
  end

endmodule
